// File: rtl/regfile_context_engine_if.sv
// Register-file context engine bundle: control, register-file port and save/restore streams.
// Pure wiring; no latency of its own.
// Backpressure: OUT_READY throttles the save stream, IN_READY throttles the restore stream.
interface regfile_context_engine_if;
    logic        START_SAVE;
    logic        START_RESTORE;
    logic        ABORT;
    logic        BUSY;
    logic        DONE;
    logic [4:0]  RF_RADDR;
    logic [31:0] RF_RDATA;
    logic [4:0]  RF_WADDR;
    logic [31:0] RF_WDATA;
    logic        RF_WEN;
    logic [31:0] OUT_DATA;
    logic        OUT_VALID;
    logic        OUT_READY;
    logic [31:0] IN_DATA;
    logic        IN_VALID;
    logic        IN_READY;

    // Environment side: issues commands, owns the register file array and both stream endpoints.
    modport master (
        output START_SAVE, START_RESTORE, ABORT, RF_RDATA, OUT_READY, IN_DATA, IN_VALID,
        input  BUSY, DONE, RF_RADDR, RF_WADDR, RF_WDATA, RF_WEN, OUT_DATA, OUT_VALID, IN_READY
    );

    // Engine side.
    modport slave (
        input  START_SAVE, START_RESTORE, ABORT, RF_RDATA, OUT_READY, IN_DATA, IN_VALID,
        output BUSY, DONE, RF_RADDR, RF_WADDR, RF_WDATA, RF_WEN, OUT_DATA, OUT_VALID, IN_READY
    );
endinterface

// File: rtl/regfile_context_engine.sv
// Streams registers FIRST_REG..LAST_REG out of (save) or into (restore) the register file.
// Latency: save 2 cycles per word (read, then hold for handshake); restore 1 cycle per word, write lands next cycle.
// Backpressure: OUT_VALID/OUT_DATA hold until OUT_READY; IN_READY high throughout restore except in an ABORT cycle.
module regfile_context_engine #(
    parameter int FIRST_REG = 1,
    parameter int LAST_REG  = 31
) (
    input  logic                       CLK,
    input  logic                       RESET,
    regfile_context_engine_if.slave    bus
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SAVE_RD = 2'd1,
        SAVE_TX = 2'd2,
        RESTORE = 2'd3
    } state_t;

    localparam logic [4:0] FIRST_IDX = 5'(FIRST_REG);
    localparam logic [4:0] LAST_IDX  = 5'(LAST_REG);

    state_t     state;
    logic [4:0] addr;
    logic       out_beat;
    logic       in_beat;

    // The read port always points at the current transfer index so RF_RDATA is ready in SAVE_RD.
    assign bus.RF_RADDR = addr;
    // ABORT drops IN_READY in the same cycle so no beat can slip in alongside the abort.
    assign bus.IN_READY = (state == RESTORE) && !bus.ABORT;
    assign out_beat     = bus.OUT_VALID && bus.OUT_READY;
    assign in_beat      = bus.IN_VALID && bus.IN_READY;

    // Single state machine; all outputs except RF_RADDR/IN_READY are registered here.
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            state         <= IDLE;
            addr          <= 5'd0;
            bus.BUSY      <= 1'b0;
            bus.DONE      <= 1'b0;
            bus.RF_WADDR  <= 5'd0;
            bus.RF_WDATA  <= 32'd0;
            bus.RF_WEN    <= 1'b0;
            bus.OUT_DATA  <= 32'd0;
            bus.OUT_VALID <= 1'b0;
        end else begin
            bus.DONE   <= 1'b0;
            bus.RF_WEN <= 1'b0;
            case (state)
                IDLE: begin
                    // ABORT beats any simultaneous start; save beats restore.
                    if (!bus.ABORT) begin
                        if (bus.START_SAVE) begin
                            state    <= SAVE_RD;
                            addr     <= FIRST_IDX;
                            bus.BUSY <= 1'b1;
                        end else if (bus.START_RESTORE) begin
                            state    <= RESTORE;
                            addr     <= FIRST_IDX;
                            bus.BUSY <= 1'b1;
                        end
                    end
                end
                SAVE_RD: begin
                    if (bus.ABORT) begin
                        state    <= IDLE;
                        bus.BUSY <= 1'b0;
                    end else begin
                        bus.OUT_DATA  <= bus.RF_RDATA;
                        bus.OUT_VALID <= 1'b1;
                        state         <= SAVE_TX;
                    end
                end
                SAVE_TX: begin
                    if (bus.ABORT) begin
                        state         <= IDLE;
                        bus.BUSY      <= 1'b0;
                        bus.OUT_VALID <= 1'b0;
                    end else if (out_beat) begin
                        bus.OUT_VALID <= 1'b0;
                        if (addr == LAST_IDX) begin
                            state    <= IDLE;
                            bus.BUSY <= 1'b0;
                            bus.DONE <= 1'b1;
                        end else begin
                            addr  <= addr + 5'd1;
                            state <= SAVE_RD;
                        end
                    end
                end
                RESTORE: begin
                    if (bus.ABORT) begin
                        state    <= IDLE;
                        bus.BUSY <= 1'b0;
                    end else if (in_beat) begin
                        bus.RF_WEN   <= 1'b1;
                        bus.RF_WADDR <= addr;
                        bus.RF_WDATA <= bus.IN_DATA;
                        if (addr == LAST_IDX) begin
                            // DONE lines up with the final write.
                            state    <= IDLE;
                            bus.BUSY <= 1'b0;
                            bus.DONE <= 1'b1;
                        end else begin
                            addr <= addr + 5'd1;
                        end
                    end
                end
                default: begin
                    state         <= IDLE;
                    bus.BUSY      <= 1'b0;
                    bus.OUT_VALID <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_regfile_context_engine.sv
// Bench for regfile_context_engine: random and directed save/restore runs against a queue model.
// Inputs driven and outputs sampled on the falling edge.
// Waits are bounded by cycle budgets plus a global time limit.
module tb_regfile_context_engine;
    localparam int FIRST = 1;
    localparam int LAST  = 31;
    localparam int NREG  = LAST - FIRST + 1;

    logic CLK = 1'b0;
    logic RESET = 1'b0;
    int   checks = 0;
    int   failures = 0;

    regfile_context_engine_if bus();

    regfile_context_engine #(.FIRST_REG(FIRST), .LAST_REG(LAST)) dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus)
    );

    always #5 CLK = ~CLK;

    logic [31:0] rf [32];
    assign bus.RF_RDATA = rf[bus.RF_RADDR];

    logic [31:0] got_q [$];
    logic [36:0] wr_q [$];
    logic [36:0] exp_q [$];
    int s_busy, s_done, s_wen, s_unstable, s_inrdy;
    bit s_timeout;
    int r_done, r_done_last, r_rdy_err, r_gap, r_busy_abort, r_oor;
    bit r_timeout;

    task automatic step();
        @(posedge CLK);
        @(negedge CLK);
    endtask

    task automatic idle_inputs();
        bus.START_SAVE = 1'b0; bus.START_RESTORE = 1'b0; bus.ABORT = 1'b0;
        bus.OUT_READY = 1'b0; bus.IN_VALID = 1'b0; bus.IN_DATA = 32'd0;
    endtask

    // Drives one save transfer and records the observed stream and side signals.
    task automatic run_save(input int stall_beat, input int stall_len, input bit rnd, input bit both);
        int stalled = 0;
        int post = 0;
        bit held = 1'b0;
        logic [31:0] held_dat = 32'd0;
        got_q.delete();
        s_busy = 0; s_done = 0; s_wen = 0; s_unstable = 0; s_inrdy = 0; s_timeout = 1'b1;
        bus.START_SAVE = 1'b1; bus.START_RESTORE = both; bus.OUT_READY = 1'b1;
        step();
        bus.START_SAVE = 1'b0; bus.START_RESTORE = 1'b0;
        for (int cyc = 0; cyc < 2000; cyc++) begin
            if (bus.BUSY) s_busy++;
            if (bus.DONE) s_done++;
            if (bus.RF_WEN) s_wen++;
            if (bus.IN_READY) s_inrdy++;
            if (held && (!bus.OUT_VALID || bus.OUT_DATA !== held_dat)) s_unstable++;
            bus.START_RESTORE = both && (cyc == 10);
            if (bus.OUT_VALID && got_q.size() == stall_beat && stalled < stall_len) begin
                bus.OUT_READY = 1'b0;
                stalled++;
            end else begin
                bus.OUT_READY = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            end
            if (bus.OUT_VALID && bus.OUT_READY) got_q.push_back(bus.OUT_DATA);
            held = bus.OUT_VALID && !bus.OUT_READY;
            held_dat = bus.OUT_DATA;
            if (s_done > 0) begin
                post++;
                if (post > 3) begin
                    s_timeout = 1'b0;
                    break;
                end
            end
            step();
        end
        bus.START_RESTORE = 1'b0; bus.OUT_READY = 1'b0;
    endtask

    // Drives one restore transfer; exp_q holds what the model says must be written, wr_q what was written.
    task automatic run_restore(input bit rnd, input int abort_after);
        int m_addr = FIRST;
        int n_acc = 0;
        int post = 0;
        int abort_cyc = -10;
        int last_wen = -1;
        bit active = 1'b1;
        exp_q.delete(); wr_q.delete();
        r_done = 0; r_done_last = 0; r_rdy_err = 0; r_gap = 0; r_busy_abort = 0; r_oor = 0; r_timeout = 1'b1;
        bus.START_RESTORE = 1'b1;
        step();
        bus.START_RESTORE = 1'b0;
        for (int cyc = 0; cyc < 2000; cyc++) begin
            if (bus.RF_WEN) begin
                wr_q.push_back({bus.RF_WADDR, bus.RF_WDATA});
                if (last_wen >= 0 && cyc != last_wen + 1 && !rnd) r_gap++;
                last_wen = cyc;
                if (int'(bus.RF_WADDR) < FIRST || int'(bus.RF_WADDR) > LAST) r_oor++;
            end
            if (bus.DONE) begin
                r_done++;
                if (bus.RF_WEN && bus.RF_WADDR == 5'(LAST)) r_done_last++;
            end
            if (cyc == abort_cyc + 1 && bus.BUSY) r_busy_abort++;
            bus.ABORT = active && abort_after > 0 && n_acc == abort_after;
            if (bus.ABORT) abort_cyc = cyc;
            bus.IN_VALID = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            bus.IN_DATA = rnd ? $urandom : 32'hA000 + m_addr;
            #1;
            if (bus.IN_READY !== (active && !bus.ABORT)) r_rdy_err++;
            if (active && !bus.ABORT && bus.IN_VALID) begin
                exp_q.push_back({5'(m_addr), bus.IN_DATA});
                m_addr++;
                n_acc++;
                if (m_addr > LAST) active = 1'b0;
            end
            if (bus.ABORT) active = 1'b0;
            if (!active) begin
                post++;
                if (post > 3) begin
                    r_timeout = 1'b0;
                    break;
                end
            end
            step();
        end
        idle_inputs();
    endtask

    task automatic test_reset();
        idle_inputs();
        bus.START_SAVE = 1'b1;
        RESET = 1'b0;
        step(); step();
        checks++;
        if ({bus.BUSY, bus.DONE, bus.RF_WEN, bus.OUT_VALID, bus.IN_READY} !== 5'b0)
            begin failures++; $display("FAIL reset_flags: got %b, required 00000", {bus.BUSY, bus.DONE, bus.RF_WEN, bus.OUT_VALID, bus.IN_READY}); end
        checks++;
        if ({bus.RF_RADDR, bus.RF_WADDR} !== 10'd0)
            begin failures++; $display("FAIL reset_addr: raddr=%0d waddr=%0d, required 0", bus.RF_RADDR, bus.RF_WADDR); end
        checks++;
        if ({bus.RF_WDATA, bus.OUT_DATA} !== 64'd0)
            begin failures++; $display("FAIL reset_data: wdata=%h out=%h, required 0", bus.RF_WDATA, bus.OUT_DATA); end
        bus.START_SAVE = 1'b0;
        RESET = 1'b1;
        step();
        checks++;
        if (bus.BUSY !== 1'b0 || bus.RF_WEN !== 1'b0)
            begin failures++; $display("FAIL reset_release: busy=%b wen=%b, required 0 0", bus.BUSY, bus.RF_WEN); end
    endtask

    task automatic test_save_basic();
        int bad = 0;
        for (int i = 0; i < 32; i++) rf[i] = 32'h100 + i;
        run_save(-1, 0, 1'b0, 1'b0);
        if (got_q.size() != NREG) bad++;
        else foreach (got_q[i]) if (got_q[i] !== 32'h100 + FIRST + i) bad++;
        checks++;
        if (bad != 0 || s_timeout) begin failures++; $display("FAIL save_stream: %0d beats, %0d wrong, timeout=%b, required %0d correct", got_q.size(), bad, s_timeout, NREG); end
        checks++;
        if (s_busy != 2 * NREG) begin failures++; $display("FAIL save_busy_cycles: got %0d, required %0d", s_busy, 2 * NREG); end
        checks++;
        if (s_done != 1) begin failures++; $display("FAIL save_done_count: got %0d, required 1", s_done); end
        checks++;
        if (s_wen != 0) begin failures++; $display("FAIL save_no_wen: got %0d writes, required 0", s_wen); end
    endtask

    task automatic test_save_stall();
        int bad = 0;
        for (int i = 0; i < 32; i++) rf[i] = 32'h100 + i;
        run_save(2, 5, 1'b0, 1'b0);
        if (got_q.size() != NREG) bad++;
        else foreach (got_q[i]) if (got_q[i] !== 32'h100 + FIRST + i) bad++;
        checks++;
        if (bad != 0 || s_timeout) begin failures++; $display("FAIL stall_stream: %0d beats, %0d wrong, required %0d correct", got_q.size(), bad, NREG); end
        checks++;
        if (s_unstable != 0) begin failures++; $display("FAIL stall_hold: %0d unstable cycles, required 0", s_unstable); end
        checks++;
        if (s_busy != 2 * NREG + 5) begin failures++; $display("FAIL stall_busy_cycles: got %0d, required %0d", s_busy, 2 * NREG + 5); end
    endtask

    task automatic test_save_random();
        for (int rep = 0; rep < 3; rep++) begin
            int bad = 0;
            for (int i = 0; i < 32; i++) rf[i] = $urandom;
            run_save(-1, 0, 1'b1, 1'b0);
            if (got_q.size() != NREG) bad++;
            else foreach (got_q[i]) if (got_q[i] !== rf[FIRST + i]) bad++;
            checks++;
            if (bad != 0 || s_timeout || s_done != 1) begin failures++; $display("FAIL save_random: rep %0d beats=%0d wrong=%0d done=%0d, required %0d 0 1", rep, got_q.size(), bad, s_done, NREG); end
            checks++;
            if (s_unstable != 0) begin failures++; $display("FAIL save_random_hold: rep %0d %0d unstable, required 0", rep, s_unstable); end
        end
    endtask

    task automatic test_restore();
        int bad = 0;
        run_restore(1'b0, 0);
        if (wr_q.size() != NREG || exp_q.size() != NREG) bad++;
        else foreach (wr_q[i]) if (wr_q[i] !== {5'(FIRST + i), 32'hA000 + FIRST + i}) bad++;
        checks++;
        if (bad != 0 || r_timeout) begin failures++; $display("FAIL restore_writes: %0d writes, %0d wrong, required %0d correct", wr_q.size(), bad, NREG); end
        checks++;
        if (r_gap != 0) begin failures++; $display("FAIL restore_consecutive: %0d gaps, required 0", r_gap); end
        checks++;
        if (r_done != 1 || r_done_last != 1) begin failures++; $display("FAIL restore_done: done=%0d with_last=%0d, required 1 1", r_done, r_done_last); end
        checks++;
        if (r_oor != 0) begin failures++; $display("FAIL restore_range: %0d out-of-range writes, required 0", r_oor); end
        checks++;
        if (r_rdy_err != 0) begin failures++; $display("FAIL restore_in_ready: %0d wrong cycles, required 0", r_rdy_err); end
    endtask

    task automatic test_restore_random();
        for (int rep = 0; rep < 3; rep++) begin
            int bad = 0;
            run_restore(1'b1, 0);
            if (wr_q.size() != exp_q.size()) bad++;
            else foreach (wr_q[i]) if (wr_q[i] !== exp_q[i]) bad++;
            checks++;
            if (bad != 0 || r_timeout || exp_q.size() != NREG) begin failures++; $display("FAIL restore_random: rep %0d writes=%0d wrong=%0d, required %0d 0", rep, wr_q.size(), bad, NREG); end
            checks++;
            if (r_rdy_err != 0 || r_done != 1 || r_done_last != 1) begin failures++; $display("FAIL restore_random_ctl: rep %0d rdy_err=%0d done=%0d with_last=%0d, required 0 1 1", rep, r_rdy_err, r_done, r_done_last); end
        end
    endtask

    task automatic test_simultaneous();
        int bad = 0;
        for (int i = 0; i < 32; i++) rf[i] = 32'h200 + i;
        run_save(-1, 0, 1'b0, 1'b1);
        if (got_q.size() != NREG) bad++;
        else foreach (got_q[i]) if (got_q[i] !== 32'h200 + FIRST + i) bad++;
        checks++;
        if (bad != 0 || s_done != 1) begin failures++; $display("FAIL both_start_save: beats=%0d wrong=%0d done=%0d, required %0d 0 1", got_q.size(), bad, s_done, NREG); end
        checks++;
        if (s_inrdy != 0 || s_wen != 0) begin failures++; $display("FAIL both_start_no_restore: in_ready=%0d wen=%0d, required 0 0", s_inrdy, s_wen); end
    endtask

    task automatic test_abort();
        int bad = 0;
        run_restore(1'b0, 10);
        if (wr_q.size() != 10) bad++;
        else foreach (wr_q[i]) if (wr_q[i] !== {5'(FIRST + i), 32'hA000 + FIRST + i}) bad++;
        checks++;
        if (bad != 0) begin failures++; $display("FAIL abort_writes: %0d writes, %0d wrong, required 10 correct", wr_q.size(), bad); end
        checks++;
        if (r_busy_abort != 0) begin failures++; $display("FAIL abort_busy: busy after abort %0d, required 0", r_busy_abort); end
        checks++;
        if (r_done != 0 || r_rdy_err != 0) begin failures++; $display("FAIL abort_done: done=%0d rdy_err=%0d, required 0 0", r_done, r_rdy_err); end
        for (int i = 0; i < 32; i++) rf[i] = 32'h300 + i;
        run_save(-1, 0, 1'b0, 1'b0);
        checks++;
        if (got_q.size() != NREG || s_done != 1 || got_q[NREG - 1] !== 32'h300 + LAST)
            begin failures++; $display("FAIL abort_then_save: beats=%0d done=%0d, required %0d 1", got_q.size(), s_done, NREG); end
    endtask

    task automatic test_back_to_back();
        bit seen = 1'b0;
        bus.START_SAVE = 1'b1; bus.OUT_READY = 1'b1;
        step();
        bus.START_SAVE = 1'b0;
        for (int cyc = 0; cyc < 300; cyc++) begin
            if (bus.DONE) begin seen = 1'b1; break; end
            step();
        end
        checks++;
        if (!seen) begin failures++; $display("FAIL b2b_done_wait: done seen=%b, required 1", seen); end
        bus.OUT_READY = 1'b0;
        bus.START_RESTORE = 1'b1;
        step();
        bus.START_RESTORE = 1'b0;
        #1;
        checks++;
        if (bus.BUSY !== 1'b1 || bus.IN_READY !== 1'b1) begin failures++; $display("FAIL b2b_restart: busy=%b in_ready=%b, required 1 1", bus.BUSY, bus.IN_READY); end
        bus.ABORT = 1'b1;
        step();
        bus.ABORT = 1'b0;
        checks++;
        if (bus.BUSY !== 1'b0 || bus.DONE !== 1'b0) begin failures++; $display("FAIL b2b_abort: busy=%b done=%b, required 0 0", bus.BUSY, bus.DONE); end
        bus.ABORT = 1'b1; bus.START_SAVE = 1'b1;
        step();
        idle_inputs();
        checks++;
        if (bus.BUSY !== 1'b0) begin failures++; $display("FAIL idle_abort_start: busy=%b, required 0", bus.BUSY); end
    endtask

    task automatic test_reset_mid();
        int beats = 0;
        int dones = 0;
        int busys = 0;
        bit found = 1'b0;
        for (int i = 0; i < 32; i++) rf[i] = 32'h100 + i;
        bus.START_SAVE = 1'b1; bus.OUT_READY = 1'b1;
        step();
        bus.START_SAVE = 1'b0;
        for (int cyc = 0; cyc < 200; cyc++) begin
            if (bus.OUT_VALID && beats == 6) begin found = 1'b1; break; end
            if (bus.OUT_VALID) beats++;
            step();
        end
        checks++;
        if (!found || bus.OUT_DATA !== 32'h107) begin failures++; $display("FAIL reset_mid_reach: found=%b data=%h, required 1 00000107", found, bus.OUT_DATA); end
        RESET = 1'b0;
        step();
        checks++;
        if ({bus.BUSY, bus.DONE, bus.RF_WEN, bus.OUT_VALID, bus.IN_READY, bus.RF_RADDR, bus.RF_WADDR} !== 15'd0 ||
            {bus.RF_WDATA, bus.OUT_DATA} !== 64'd0)
            begin failures++; $display("FAIL reset_mid_outputs: busy=%b ov=%b raddr=%0d out=%h, required all 0", bus.BUSY, bus.OUT_VALID, bus.RF_RADDR, bus.OUT_DATA); end
        RESET = 1'b1;
        for (int cyc = 0; cyc < 80; cyc++) begin
            if (bus.DONE) dones++;
            if (bus.BUSY) busys++;
            step();
        end
        idle_inputs();
        checks++;
        if (dones != 0 || busys != 0) begin failures++; $display("FAIL reset_mid_after: done=%0d busy=%0d, required 0 0", dones, busys); end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        for (int i = 0; i < 32; i++) rf[i] = 32'd0;
        idle_inputs();
        @(negedge CLK);
        test_reset();
        test_save_basic();
        test_save_stall();
        test_save_random();
        test_restore();
        test_restore_random();
        test_simultaneous();
        test_abort();
        test_back_to_back();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/regfile_context_engine.md
REGFILE_CONTEXT_ENGINE -- requirements
Module: regfile_context_engine

Interface
REQ-001 Parameter FIRST_REG, default 1: lowest register index transferred (x0 excluded by default).
REQ-002 Parameter LAST_REG, default 31: highest register index transferred; FIRST_REG <= LAST_REG <= 31.
REQ-003 CLK  in  1  clock; all state changes on rising edge.
REQ-004 RESET  in  1  reset, synchronous, active-low.
REQ-005 START_SAVE  in  1  request to stream registers FIRST_REG..LAST_REG out.
REQ-006 START_RESTORE  in  1  request to stream registers FIRST_REG..LAST_REG in.
REQ-007 ABORT  in  1  terminate any transfer.
REQ-008 BUSY  out  1  engine owns register file ports; pipeline stalls while high.
REQ-009 DONE  out  1  single-cycle completion pulse.
REQ-010 RF_RADDR  out  5  register file read address, drives OUT1_ADDRESS.
REQ-011 RF_RDATA  in  32  combinational read data for RF_RADDR.
REQ-012 RF_WADDR  out  5  register file write address.
REQ-013 RF_WDATA  out  32  register file write data.
REQ-014 RF_WEN  out  1  register file write enable.
REQ-015 OUT_DATA / OUT_VALID / OUT_READY  out/out/in  32/1/1  save stream, valid-ready.
REQ-016 IN_DATA / IN_VALID / IN_READY  in/in/out  32/1/1  restore stream, valid-ready.

Function
REQ-017 States SHALL be IDLE, SAVE_RD, SAVE_TX, RESTORE; BUSY = (state != IDLE), registered.
REQ-018 IDLE + START_SAVE -> SAVE_RD with addr = FIRST_REG; START_SAVE and START_RESTORE together: save wins.
REQ-019 IDLE + START_RESTORE (no START_SAVE) -> RESTORE with addr = FIRST_REG.
REQ-020 START_* while BUSY SHALL be ignored.
REQ-021 RF_RADDR SHALL equal the addr register at all times.
REQ-022 SAVE_RD: capture RF_RDATA into OUT_DATA, -> SAVE_TX (one cycle).
REQ-023 SAVE_TX: OUT_VALID = 1, OUT_DATA stable until OUT_VALID && OUT_READY.
REQ-024 SAVE_TX handshake: addr < LAST_REG -> addr+1, SAVE_RD; addr == LAST_REG -> IDLE, DONE = 1 next cycle.
REQ-025 Save throughput: one word per 2 cycles minimum; (LAST_REG-FIRST_REG+1) beats exactly, ascending index order.
REQ-026 RESTORE: IN_READY = 1 unless ABORT is high this cycle.
REQ-027 Accepted beat (IN_VALID && IN_READY): RF_WDATA <= IN_DATA, RF_WADDR <= addr, RF_WEN = 1 for exactly the next cycle.
REQ-028 Restore throughput: one word per cycle; addr increments per beat; beat at LAST_REG -> IDLE, DONE asserted in same cycle as final RF_WEN.
REQ-029 RF_WEN SHALL never assert for an index outside FIRST_REG..LAST_REG, and never in save mode.
REQ-030 ABORT in any BUSY state -> IDLE next cycle, no DONE, OUT_VALID low next cycle, no further beat accepted; an RF_WEN from a beat accepted before the ABORT cycle still completes.
REQ-031 ABORT in IDLE has no effect; ABORT with START_* in IDLE: ABORT wins, stays IDLE.
REQ-032 DONE high exactly one cycle per completed transfer; returning to IDLE permits new START in that same DONE cycle.

Reset
REQ-033 RESET low at a clock edge SHALL force IDLE, addr = 0, and all outputs (BUSY, DONE, RF_RADDR, RF_WADDR, RF_WDATA, RF_WEN, OUT_DATA, OUT_VALID, IN_READY) to 0, overriding all other inputs including mid-transfer.
REQ-034 No RF_WEN SHALL occur in the cycle after a reset edge.

Verification
REQ-035 Save, OUT_READY=1, RF preloaded x[i]=0x100+i -> 31 beats 0x101..0x11F, 62 BUSY cycles, DONE once, RF_WEN never high.
REQ-036 Save with OUT_READY held low 5 cycles on beat 3 -> OUT_DATA 0x103 stable with OUT_VALID high throughout, stream resumes intact.
REQ-037 Restore, IN_VALID=1, data 0xA000+i -> RF_WEN 31 consecutive cycles at addresses 1..31 with 0xA001..0xA01F, DONE with last write, x0 never written.
REQ-038 START_SAVE and START_RESTORE same cycle -> save performed; START_RESTORE during save ignored.
REQ-039 ABORT after restore beat 10 -> writes to x1..x10 only, BUSY low next cycle, no DONE; new START_SAVE then completes normally.
REQ-040 RESET low mid-save at beat 7 -> all outputs 0 next cycle, IDLE, DONE never asserted.
